// File: rtl/nco_sweep_ctrl_pkg.sv
// nco_sweep_ctrl_pkg: sweep mode codes and FSM state encoding shared with the nco block
package nco_sweep_ctrl_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DWELL = 1'b1
  } state_t;
  localparam logic [1:0] NCO_MODE_SINGLE   = 2'd0;
  localparam logic [1:0] NCO_MODE_REPEAT   = 2'd1;
  localparam logic [1:0] NCO_MODE_PINGPONG = 2'd2;
  function automatic logic is_single(input logic [1:0] mode);
    return (mode != NCO_MODE_REPEAT) && (mode != NCO_MODE_PINGPONG);
  endfunction
endpackage

// File: rtl/nco_sweep_ctrl_dwell_timer.sv
// nco_sweep_ctrl_dwell_timer: loadable down-counter that parks at zero and flags it
module nco_sweep_ctrl_dwell_timer #(
  parameter int gp_width = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic                i_ena,
  input  logic [gp_width-1:0] i_value,
  output logic                o_zero
);
  logic [gp_width-1:0] cnt;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt <= '0;
    else if (i_load) cnt <= i_value;
    else if (i_ena && cnt != '0) cnt <= cnt - 1'b1;
  assign o_zero = (cnt == '0);
endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: start/stop/step frequency sweep sequencer driving the nco tuning word
module nco_sweep_ctrl
  import nco_sweep_ctrl_pkg::*;
#(
  parameter int gp_ftw_width   = 8,
  parameter int gp_dwell_width = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_ena,
  input  logic                      i_start,
  input  logic                      i_abort,
  input  logic [1:0]                i_mode,
  input  logic [gp_ftw_width-1:0]   i_f_start,
  input  logic [gp_ftw_width-1:0]   i_f_stop,
  input  logic [gp_ftw_width-1:0]   i_f_step,
  input  logic [gp_dwell_width-1:0] i_dwell,
  output logic [gp_ftw_width-1:0]   o_ftw,
  output logic                      o_nco_ena,
  output logic                      o_busy,
  output logic                      o_step,
  output logic                      o_done
);
  localparam int W = gp_ftw_width;
  state_t                    state_q, state_d;
  logic [1:0]                mode_q;
  logic [W-1:0]              f_start_q, f_stop_q, step_q, tgt_q, tgt_flip;
  logic [gp_dwell_width-1:0] dwell_q;
  logic                      dir_up_q;
  logic                      cnt_zero, start_ok, at_end, end_step, finish;
  // one step toward tgt in W+1 bits so overshoot or wrap is caught and clamped
  function automatic logic [W-1:0] step_to(input logic [W-1:0] cur, stp, tgt, input logic up);
    logic [W:0] s;
    s = up ? {1'b0, cur} + {1'b0, stp} : {1'b0, cur} - {1'b0, stp};
    return up ? ((s > {1'b0, tgt}) ? tgt : s[W-1:0])
              : ((s[W] || s[W-1:0] < tgt) ? tgt : s[W-1:0]);
  endfunction
  assign start_ok = i_start && !i_abort && state_q == ST_IDLE;
  assign at_end   = (o_ftw == tgt_q) || (step_q == '0);
  assign end_step = state_q == ST_DWELL && cnt_zero && !i_abort;
  assign finish   = end_step && at_end && is_single(mode_q);
  assign tgt_flip = (tgt_q == f_stop_q) ? f_start_q : f_stop_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state_q <= ST_IDLE;
    else if (i_ena) state_q <= state_d;
  always_comb
    state_d = i_abort ? ST_IDLE : start_ok ? ST_DWELL : finish ? ST_IDLE : state_q;
  always_comb begin
    o_busy    = state_q == ST_DWELL;
    o_nco_ena = state_q == ST_DWELL;
  end
  nco_sweep_ctrl_dwell_timer #(.gp_width(gp_dwell_width)) u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (i_ena && (start_ok || (end_step && !finish))),
    .i_ena  (i_ena && state_q == ST_DWELL),
    .i_value(start_ok ? i_dwell : dwell_q),
    .o_zero (cnt_zero)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      o_ftw     <= '0;
      o_step    <= 1'b0;
      o_done    <= 1'b0;
      mode_q    <= NCO_MODE_SINGLE;
      f_start_q <= '0;
      f_stop_q  <= '0;
      step_q    <= '0;
      tgt_q     <= '0;
      dwell_q   <= '0;
      dir_up_q  <= 1'b1;
    end else if (i_ena) begin
      o_step <= 1'b0;
      o_done <= 1'b0;
      if (start_ok) begin
        mode_q    <= i_mode;
        f_start_q <= i_f_start;
        f_stop_q  <= i_f_stop;
        step_q    <= i_f_step;
        dwell_q   <= i_dwell;
        tgt_q     <= i_f_stop;
        dir_up_q  <= i_f_stop >= i_f_start;
        o_ftw     <= i_f_start;
      end else if (end_step) begin
        if (!at_end) begin
          o_ftw  <= step_to(o_ftw, step_q, tgt_q, dir_up_q);
          o_step <= 1'b1;
        end else if (mode_q == NCO_MODE_REPEAT) begin
          o_ftw  <= f_start_q;
          o_step <= 1'b1;
        end else if (mode_q == NCO_MODE_PINGPONG) begin
          tgt_q    <= tgt_flip;
          dir_up_q <= !dir_up_q;
          o_ftw    <= step_to(o_ftw, step_q, tgt_flip, !dir_up_q);
          o_step   <= 1'b1;
        end else
          o_done <= 1'b1;
      end
    end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: directed vector table plus async-reset sequence for nco_sweep_ctrl
module tb_nco_sweep_ctrl;
  logic clk = 0, rst = 1, ena = 1, start = 0, abort = 0;
  logic [1:0] mode = 0;
  logic [7:0] f_start = 0, f_stop = 0, f_step = 0;
  logic [15:0] dwell = 0;
  logic [7:0] ftw;
  logic nco_ena, busy, stp, done;
  always #5 clk = ~clk;
  nco_sweep_ctrl #(.gp_ftw_width(8), .gp_dwell_width(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_ena(ena), .i_start(start), .i_abort(abort),
    .i_mode(mode), .i_f_start(f_start), .i_f_stop(f_stop), .i_f_step(f_step),
    .i_dwell(dwell), .o_ftw(ftw), .o_nco_ena(nco_ena), .o_busy(busy),
    .o_step(stp), .o_done(done)
  );
  typedef struct {
    logic        start, abort, ena;
    logic [1:0]  mode;
    logic [7:0]  fs, fe, st;
    logic [15:0] dw;
    logic [7:0]  eftw;
    logic        ebusy, estep, edone;
    string       tag;
  } vec_t;
  vec_t tbl[$];
  vec_t c;
  int nvec = 0, nerr = 0;
  task automatic cfg(input string tag, input logic [1:0] m, input logic [7:0] fs, fe, st, input logic [15:0] dw);
    c.tag = tag; c.mode = m; c.fs = fs; c.fe = fe; c.st = st; c.dw = dw;
  endtask
  task automatic add(input logic s, a, e, input logic [7:0] eftw, input logic eb, es, ed);
    vec_t v;
    v = c;
    v.start = s; v.abort = a; v.ena = e;
    v.eftw = eftw; v.ebusy = eb; v.estep = es; v.edone = ed;
    tbl.push_back(v);
  endtask
  task automatic check(input string name, input logic [7:0] eftw, input logic eb, es, ed);
    nvec++;
    if ({ftw, busy, nco_ena, stp, done} !== {eftw, eb, eb, es, ed}) begin
      nerr++;
      $display("FAIL %s: got ftw=%0d busy=%b nco_ena=%b step=%b done=%b, want ftw=%0d busy=%b nco_ena=%b step=%b done=%b",
               name, ftw, busy, nco_ena, stp, done, eftw, eb, eb, es, ed);
    end
  endtask
  task automatic run_tbl();
    foreach (tbl[i]) begin
      start = tbl[i].start; abort = tbl[i].abort; ena = tbl[i].ena; mode = tbl[i].mode;
      f_start = tbl[i].fs; f_stop = tbl[i].fe; f_step = tbl[i].st; dwell = tbl[i].dw;
      @(posedge clk); #1;
      check($sformatf("%s[%0d]", tbl[i].tag, i), tbl[i].eftw, tbl[i].ebusy, tbl[i].estep, tbl[i].edone);
    end
    tbl.delete();
    start = 0; abort = 0; ena = 1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 check("reset", 8'd0, 0, 0, 0);
    rst = 0;
    cfg("single", 2'd0, 8'd10, 8'd40, 8'd10, 16'd2);
    add(1,0,1, 10,1,0,0); add(0,0,1, 10,1,0,0); add(0,0,1, 10,1,0,0);
    add(0,0,1, 20,1,1,0); add(0,0,1, 20,1,0,0); add(0,0,1, 20,1,0,0);
    add(0,0,1, 30,1,1,0); add(0,0,1, 30,1,0,0); add(0,0,1, 30,1,0,0);
    add(0,0,1, 40,1,1,0); add(0,0,1, 40,1,0,0); add(0,0,1, 40,1,0,0);
    add(0,0,1, 40,0,0,1); add(0,0,1, 40,0,0,0);
    cfg("clamp", 2'd3, 8'd10, 8'd35, 8'd10, 16'd0);
    add(1,0,1, 10,1,0,0); add(0,0,1, 20,1,1,0); add(0,0,1, 30,1,1,0);
    add(0,0,1, 35,1,1,0); add(0,0,1, 35,0,0,1); add(0,0,1, 35,0,0,0);
    cfg("pingpong", 2'd2, 8'd40, 8'd10, 8'd15, 16'd0);
    add(1,0,1, 40,1,0,0); add(0,0,1, 25,1,1,0); add(0,0,1, 10,1,1,0);
    add(0,0,1, 25,1,1,0); add(0,0,1, 40,1,1,0); add(0,0,1, 25,1,1,0);
    add(0,1,1, 25,0,0,0); add(0,0,1, 25,0,0,0); add(1,1,1, 25,0,0,0);
    cfg("repeat", 2'd1, 8'd250, 8'd255, 8'd10, 16'd1);
    add(1,0,1, 250,1,0,0); add(0,0,1, 250,1,0,0); add(0,0,1, 255,1,1,0);
    add(0,0,1, 255,1,0,0); add(0,0,1, 250,1,1,0); add(0,0,1, 250,1,0,0);
    add(0,0,1, 255,1,1,0); add(0,1,1, 255,0,0,0); add(0,0,1, 255,0,0,0);
    cfg("ena_gap", 2'd0, 8'd10, 8'd40, 8'd10, 16'd2);
    add(1,0,1, 10,1,0,0); add(0,0,0, 10,1,0,0); add(0,0,1, 10,1,0,0);
    add(0,0,0, 10,1,0,0); add(0,0,1, 10,1,0,0); add(0,0,1, 20,1,1,0);
    add(0,0,0, 20,1,1,0); add(1,0,1, 20,1,0,0); add(0,0,1, 20,1,0,0);
    add(0,0,1, 30,1,1,0); add(0,0,1, 30,1,0,0); add(0,0,1, 30,1,0,0);
    add(0,0,1, 40,1,1,0); add(0,0,0, 40,1,1,0); add(0,0,1, 40,1,0,0);
    add(0,0,1, 40,1,0,0); add(0,0,1, 40,0,0,1); add(0,0,0, 40,0,0,1);
    add(0,0,1, 40,0,0,0);
    run_tbl();
    cfg("pre_rst", 2'd0, 8'd10, 8'd40, 8'd10, 16'd2);
    add(1,0,1, 10,1,0,0); add(0,0,1, 10,1,0,0); add(0,0,1, 10,1,0,0);
    add(0,0,1, 20,1,1,0);
    run_tbl();
    #2 rst = 1;
    #1 check("async_rst", 8'd0, 0, 0, 0);
    @(posedge clk); #1 check("rst_hold", 8'd0, 0, 0, 0);
    rst = 0;
    cfg("step0", 2'd0, 8'd77, 8'd90, 8'd0, 16'd1);
    add(1,0,1, 77,1,0,0); add(0,0,1, 77,1,0,0); add(0,0,1, 77,0,0,1);
    add(0,0,1, 77,0,0,0);
    cfg("after_rst", 2'd0, 8'd5, 8'd3, 8'd1, 16'd0);
    add(1,0,1, 5,1,0,0); add(0,0,1, 4,1,1,0); add(0,0,1, 3,1,1,0);
    add(0,0,1, 3,0,0,1);
    run_tbl();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
